// File: rtl/pipeline_ctrl_if.sv
// Pipeline hazard/control bus: the hazard-relevant fields of each stage plus the
// enables, flushes and data-memory handshake the controller drives back.
interface pipeline_ctrl_if;
  logic [4:0]  id_Rs;
  logic [4:0]  id_Rt;
  logic [4:0]  ex_Rw;
  logic        ex_RegWr;
  logic        ex_MemtoReg;
  logic [4:0]  mem_Rw;
  logic        mem_RegWr;
  logic [4:0]  wr_Rw;
  logic        wr_RegWr;
  logic        mem_access;
  logic        dmem_ack;
  logic        ex_branch_taken;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wr_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wr_bubble;
  logic        dmem_req;
  logic [1:0]  forwardA;
  logic [1:0]  forwardB;
  logic [15:0] stall_cnt;
  logic        dmem_timeout;

  modport master (
    output id_Rs, id_Rt, ex_Rw, ex_RegWr, ex_MemtoReg, mem_Rw, mem_RegWr,
           wr_Rw, wr_RegWr, mem_access, dmem_ack, ex_branch_taken,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wr_en, if_id_flush,
           id_ex_flush, mem_wr_bubble, dmem_req, forwardA, forwardB,
           stall_cnt, dmem_timeout
  );

  modport slave (
    input  id_Rs, id_Rt, ex_Rw, ex_RegWr, ex_MemtoReg, mem_Rw, mem_RegWr,
           wr_Rw, wr_RegWr, mem_access, dmem_ack, ex_branch_taken,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wr_en, if_id_flush,
           id_ex_flush, mem_wr_bubble, dmem_req, forwardA, forwardB,
           stall_cnt, dmem_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: load-use stall, branch flush, data-memory wait
// with timeout, operand forwarding select and a saturating stall counter.
module pipeline_ctrl (
  input  logic            Clk,
  input  logic            Rst_n,
  pipeline_ctrl_if.slave  bus
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic [15:0] stall_cnt_reg;
  logic        timeout_reg, timeout_next;

  logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wr_en_c;
  logic if_id_flush_c, id_ex_flush_c, bubble_c, dmem_req_c;
  logic mem_stall, lu_hazard;

  assign mem_stall = bus.mem_access && !bus.dmem_ack;
  assign lu_hazard = bus.ex_MemtoReg && bus.ex_RegWr && (bus.ex_Rw != 5'd0) &&
                     ((bus.ex_Rw == bus.id_Rs) || (bus.ex_Rw == bus.id_Rt));

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = timeout_reg;
    pc_en_c       = 1'b1;
    if_id_en_c    = 1'b1;
    id_ex_en_c    = 1'b1;
    ex_mem_en_c   = 1'b1;
    mem_wr_en_c   = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    bubble_c      = 1'b0;
    dmem_req_c    = bus.mem_access;

    case (state_reg)
      RUN, LU_STALL: begin
        if (mem_stall) begin
          {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wr_en_c} = 5'b0;
          state_next    = MEM_WAIT;
          wait_cnt_next = 4'd0;
        end else if (state_reg == LU_STALL) begin
          state_next = RUN;
        end else if (bus.ex_branch_taken) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (lu_hazard) begin
          // The dependent instruction holds in ID while a bubble enters EX.
          pc_en_c       = 1'b0;
          if_id_en_c    = 1'b0;
          id_ex_flush_c = 1'b1;
          state_next    = LU_STALL;
        end
      end
      MEM_WAIT: begin
        dmem_req_c = !bus.dmem_ack;
        if (bus.dmem_ack) begin
          state_next    = RUN;
          wait_cnt_next = 4'd0;
        end else if (wait_cnt_reg == 4'hF) begin
          // Give up on the access: release the pipe and squash the MEM result.
          bubble_c      = 1'b1;
          state_next    = RUN;
          wait_cnt_next = 4'd0;
        end else begin
          {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wr_en_c} = 5'b0;
          wait_cnt_next = wait_cnt_reg + 4'd1;
          if (wait_cnt_reg == 4'hE)
            timeout_next = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase

    if (!Rst_n) begin
      {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wr_en_c} = 5'b11111;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;
      bubble_c      = 1'b0;
      dmem_req_c    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= 4'd0;
      stall_cnt_reg <= 16'd0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
      if (!pc_en_c && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  // Operand forwarding: index 0 is the Rs operand, index 1 the Rt operand.
  logic [4:0] fwd_src [2];
  logic [1:0] fwd_sel [2];

  assign fwd_src[0] = bus.id_Rs;
  assign fwd_src[1] = bus.id_Rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] =
        (bus.mem_RegWr && (bus.mem_Rw != 5'd0) && (bus.mem_Rw == fwd_src[gi])) ? 2'b10 :
        (bus.wr_RegWr  && (bus.wr_Rw  != 5'd0) && (bus.wr_Rw  == fwd_src[gi])) ? 2'b01 :
                                                                                 2'b00;
    end
  endgenerate

  assign bus.forwardA      = fwd_sel[0];
  assign bus.forwardB      = fwd_sel[1];
  assign bus.pc_en         = pc_en_c;
  assign bus.if_id_en      = if_id_en_c;
  assign bus.id_ex_en      = id_ex_en_c;
  assign bus.ex_mem_en     = ex_mem_en_c;
  assign bus.mem_wr_en     = mem_wr_en_c;
  assign bus.if_id_flush   = if_id_flush_c;
  assign bus.id_ex_flush   = id_ex_flush_c;
  assign bus.mem_wr_bubble = bubble_c;
  assign bus.dmem_req      = dmem_req_c;
  assign bus.stall_cnt     = stall_cnt_reg;
  assign bus.dmem_timeout  = timeout_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl: hazards, branch flush, memory wait,
// timeout, reset during a wait and forwarding selects.
module tb_pipeline_ctrl;

  logic Clk;
  logic Rst_n;
  int   nvec;
  int   nerr;

  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // {pc, if_id, id_ex, ex_mem, mem_wr enables, if_id_flush, id_ex_flush, bubble, req}
  wire [8:0] ctl = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wr_en,
                    bus.if_id_flush, bus.id_ex_flush, bus.mem_wr_bubble, bus.dmem_req};

  localparam logic [8:0] RUN_IDLE = 9'b11111_000_0;
  localparam logic [8:0] RUN_REQ  = 9'b11111_000_1;
  localparam logic [8:0] FREEZE   = 9'b00000_000_1;
  localparam logic [8:0] BR_FLUSH = 9'b11111_110_0;
  localparam logic [8:0] TO_BUB   = 9'b11111_001_1;

  // Inputs change just after the rising edge; outputs are read at the falling edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    bus.id_Rs = 5'd0;  bus.id_Rt = 5'd0;
    bus.ex_Rw = 5'd0;  bus.ex_RegWr = 1'b0; bus.ex_MemtoReg = 1'b0;
    bus.mem_Rw = 5'd0; bus.mem_RegWr = 1'b0;
    bus.wr_Rw = 5'd0;  bus.wr_RegWr = 1'b0;
    bus.mem_access = 1'b0; bus.dmem_ack = 1'b0; bus.ex_branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    idle_inputs();
    bus.mem_access = 1'b1;
    bus.ex_branch_taken = 1'b1;
    tick(); tick();
    sample();
    nvec++;
    if (ctl !== RUN_IDLE) begin
      nerr++; $display("FAIL reset_ctl: got %b expected %b", ctl, RUN_IDLE);
    end
    nvec++;
    if (bus.stall_cnt !== 16'd0 || bus.dmem_timeout !== 1'b0) begin
      nerr++; $display("FAIL reset_regs: stall_cnt %0d timeout %b expected 0 0", bus.stall_cnt, bus.dmem_timeout);
    end
    tick();
    Rst_n = 1'b1;
    idle_inputs();
    sample();
    nvec++;
    if (ctl !== RUN_IDLE) begin
      nerr++; $display("FAIL run_idle: got %b expected %b", ctl, RUN_IDLE);
    end
    $display("reset: ctl=%b stall_cnt=%0d", ctl, bus.stall_cnt);
  endtask

  task automatic test_load_use();
    tick();
    bus.ex_MemtoReg = 1'b1; bus.ex_RegWr = 1'b1; bus.ex_Rw = 5'd5; bus.id_Rs = 5'd5;
    sample();
    nvec++;
    if ({bus.pc_en, bus.if_id_en, bus.id_ex_flush, bus.ex_mem_en, bus.mem_wr_en, bus.if_id_flush} !== 6'b001110) begin
      nerr++; $display("FAIL lu_stall: pc/ifid/flush/exmem/memwr/ifflush got %b expected 001110",
        {bus.pc_en, bus.if_id_en, bus.id_ex_flush, bus.ex_mem_en, bus.mem_wr_en, bus.if_id_flush});
    end
    tick();
    bus.ex_MemtoReg = 1'b0; bus.ex_RegWr = 1'b0; bus.ex_Rw = 5'd0;
    bus.mem_Rw = 5'd5; bus.mem_RegWr = 1'b1;
    sample();
    nvec++;
    if (ctl !== RUN_IDLE || bus.forwardA !== 2'b10 || bus.stall_cnt !== 16'd1) begin
      nerr++; $display("FAIL lu_followup: ctl %b fwdA %b stall_cnt %0d expected %b 10 1",
        ctl, bus.forwardA, bus.stall_cnt, RUN_IDLE);
    end
    // Hazard through Rt with r0 as destination must not stall.
    tick();
    idle_inputs();
    bus.ex_MemtoReg = 1'b1; bus.ex_RegWr = 1'b1; bus.ex_Rw = 5'd0; bus.id_Rt = 5'd0;
    sample();
    nvec++;
    if (ctl !== RUN_IDLE) begin
      nerr++; $display("FAIL lu_r0: got %b expected %b", ctl, RUN_IDLE);
    end
    $display("load_use: stall_cnt=%0d", bus.stall_cnt);
  endtask

  task automatic test_zero_wait();
    tick();
    idle_inputs();
    bus.mem_access = 1'b1; bus.dmem_ack = 1'b1;
    sample();
    nvec++;
    if (ctl !== RUN_REQ || bus.stall_cnt !== 16'd1) begin
      nerr++; $display("FAIL zero_wait: ctl %b stall_cnt %0d expected %b 1", ctl, bus.stall_cnt, RUN_REQ);
    end
    $display("zero_wait: ctl=%b", ctl);
  endtask

  task automatic test_branch();
    tick();
    idle_inputs();
    bus.ex_MemtoReg = 1'b1; bus.ex_RegWr = 1'b1; bus.ex_Rw = 5'd9; bus.id_Rt = 5'd9;
    bus.ex_branch_taken = 1'b1;
    sample();
    nvec++;
    if (ctl !== BR_FLUSH) begin
      nerr++; $display("FAIL branch_flush: got %b expected %b", ctl, BR_FLUSH);
    end
    // Still in RUN: the unchanged hazard now stalls.
    tick();
    bus.ex_branch_taken = 1'b0;
    sample();
    nvec++;
    if (bus.pc_en !== 1'b0 || bus.if_id_flush !== 1'b0) begin
      nerr++; $display("FAIL branch_no_lustall: pc_en %b if_id_flush %b expected 0 0", bus.pc_en, bus.if_id_flush);
    end
    tick();
    idle_inputs();
    sample();
    nvec++;
    if (ctl !== RUN_IDLE || bus.stall_cnt !== 16'd2) begin
      nerr++; $display("FAIL branch_after: ctl %b stall_cnt %0d expected %b 2", ctl, bus.stall_cnt, RUN_IDLE);
    end
    $display("branch: stall_cnt=%0d", bus.stall_cnt);
  endtask

  task automatic test_mem_wait();
    tick();
    idle_inputs();
    bus.mem_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      nvec++;
      if (ctl !== FREEZE) begin
        nerr++; $display("FAIL mem_wait_%0d: got %b expected %b", i, ctl, FREEZE);
      end
      tick();
    end
    bus.dmem_ack = 1'b1;
    sample();
    nvec++;
    if (ctl[8:4] !== 5'b11111 || bus.dmem_req !== 1'b0) begin
      nerr++; $display("FAIL mem_ack: enables %b req %b expected 11111 0", ctl[8:4], bus.dmem_req);
    end
    tick();
    idle_inputs();
    sample();
    nvec++;
    if (ctl !== RUN_IDLE || bus.stall_cnt !== 16'd5) begin
      nerr++; $display("FAIL mem_done: ctl %b stall_cnt %0d expected %b 5", ctl, bus.stall_cnt, RUN_IDLE);
    end
    $display("mem_wait: stall_cnt=%0d", bus.stall_cnt);
  endtask

  task automatic test_timeout();
    tick();
    idle_inputs();
    bus.mem_access = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sample();
      nvec++;
      if (ctl !== FREEZE || bus.dmem_timeout !== 1'b0) begin
        nerr++; $display("FAIL timeout_wait_%0d: ctl %b timeout %b expected %b 0", i, ctl, bus.dmem_timeout, FREEZE);
      end
      tick();
    end
    sample();
    nvec++;
    if (ctl !== TO_BUB || bus.dmem_timeout !== 1'b1) begin
      nerr++; $display("FAIL timeout_bubble: ctl %b timeout %b expected %b 1", ctl, bus.dmem_timeout, TO_BUB);
    end
    tick();
    bus.mem_access = 1'b0;
    sample();
    nvec++;
    if (ctl !== RUN_IDLE || bus.dmem_timeout !== 1'b1 || bus.stall_cnt !== 16'd21) begin
      nerr++; $display("FAIL timeout_after: ctl %b timeout %b stall_cnt %0d expected %b 1 21",
        ctl, bus.dmem_timeout, bus.stall_cnt, RUN_IDLE);
    end
    $display("timeout: timeout=%b stall_cnt=%0d", bus.dmem_timeout, bus.stall_cnt);
  endtask

  task automatic test_reset_mid_wait();
    tick();
    bus.mem_access = 1'b1;
    tick();
    tick();
    Rst_n = 1'b0;
    sample();
    nvec++;
    if (ctl !== RUN_IDLE) begin
      nerr++; $display("FAIL rst_wait_outputs: got %b expected %b", ctl, RUN_IDLE);
    end
    tick();
    Rst_n = 1'b1;
    bus.mem_access = 1'b0;
    sample();
    nvec++;
    if (ctl !== RUN_IDLE || bus.stall_cnt !== 16'd0 || bus.dmem_timeout !== 1'b0) begin
      nerr++; $display("FAIL rst_wait_regs: ctl %b stall_cnt %0d timeout %b expected %b 0 0",
        ctl, bus.stall_cnt, bus.dmem_timeout, RUN_IDLE);
    end
    // A fresh request must be seen from RUN, not a leftover MEM_WAIT.
    tick();
    bus.mem_access = 1'b1; bus.dmem_ack = 1'b1;
    sample();
    nvec++;
    if (ctl !== RUN_REQ) begin
      nerr++; $display("FAIL rst_wait_run: got %b expected %b", ctl, RUN_REQ);
    end
    $display("reset_mid_wait: stall_cnt=%0d timeout=%b", bus.stall_cnt, bus.dmem_timeout);
  endtask

  task automatic test_forward();
    // {id_Rs, id_Rt, mem_Rw, mem_RegWr, wr_Rw, wr_RegWr, fwdA, fwdB}
    logic [25:0] vec [6];
    vec[0] = {5'd7, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 2'b10, 2'b10};
    vec[1] = {5'd7, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 2'b01, 2'b01};
    vec[2] = {5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00};
    vec[3] = {5'd7, 5'd3, 5'd7, 1'b1, 5'd3, 1'b1, 2'b10, 2'b01};
    vec[4] = {5'd7, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 2'b01, 2'b00};
    vec[5] = {5'd4, 5'd6, 5'd6, 1'b1, 5'd4, 1'b0, 2'b00, 2'b10};
    for (int i = 0; i < 6; i++) begin
      tick();
      idle_inputs();
      {bus.id_Rs, bus.id_Rt, bus.mem_Rw, bus.mem_RegWr, bus.wr_Rw, bus.wr_RegWr} = vec[i][25:4];
      sample();
      nvec++;
      if ({bus.forwardA, bus.forwardB} !== vec[i][3:0]) begin
        nerr++; $display("FAIL forward_%0d: fwdA/B got %b expected %b", i, {bus.forwardA, bus.forwardB}, vec[i][3:0]);
      end
      $display("forward_%0d: fwdA=%b fwdB=%b", i, bus.forwardA, bus.forwardB);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_load_use();
    test_zero_wait();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_forward();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL provide the following ports:
- Clk  in  1  single clock, all state updates on rising edge
- Rst_n  in  1  synchronous reset, active-low, sampled on rising Clk
- id_Rs, id_Rt  in  5 each  source register numbers of the instruction in ID
- ex_Rw  in  5  destination register in EX
- ex_RegWr, ex_MemtoReg  in  1 each  EX instruction writes a register / is a load
- mem_Rw  in  5  destination register in MEM
- mem_RegWr  in  1  MEM instruction writes a register
- wr_Rw  in  5  destination register in WR
- wr_RegWr  in  1  WR instruction writes a register
- mem_access  in  1  MEM instruction performs a data-memory read or write
- dmem_ack  in  1  data memory completes the access this cycle
- ex_branch_taken  in  1  branch or jump resolved taken in EX
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wr_en  out  1 each  pipeline-register load enables
- if_id_flush, id_ex_flush  out  1 each  load a NOP or bubble with all control bits 0 on the next edge
- mem_wr_bubble  out  1  mem_wr captures RegWr=0 and MemtoReg=0 this edge
- dmem_req  out  1  data-memory request strobe
- forwardA, forwardB  out  2 each  ALU operand select: 00 = register file, 01 = mem_wr, 10 = ex_mem
- stall_cnt  out  16  saturating count of stalled cycles
- dmem_timeout  out  1  sticky error flag

Function
REQ-002 The FSM SHALL have three states: RUN, LU_STALL and MEM_WAIT. Reset state is RUN.
REQ-003 A load-use hazard SHALL be detected when ex_MemtoReg=1, ex_RegWr=1, ex_Rw!=0, and ex_Rw equals id_Rs or id_Rt.
REQ-004 In RUN with mem_access=1 and dmem_ack=0, the block SHALL:
- go to MEM_WAIT on the next edge;
- drive all five enables 0 and dmem_req=1 in that cycle.
This rule has the highest priority.
REQ-005 In RUN with ex_branch_taken=1, and REQ-004 not active, the block SHALL drive if_id_flush=1 and id_ex_flush=1 for exactly one cycle. All enables SHALL be 1. The branch overrides a simultaneous load-use hazard, and the FSM stays in RUN.
REQ-006 In RUN with a load-use hazard, and neither REQ-004 nor REQ-005 active, the block SHALL:
- drive pc_en=0, if_id_en=0 and id_ex_flush=1, with ex_mem_en=1 and mem_wr_en=1;
- go to LU_STALL.
REQ-007 LU_STALL SHALL last exactly one cycle with all enables 1 and no flush, then return to RUN. If mem_access=1 and dmem_ack=0 in this cycle, REQ-004 behaviour applies instead.
REQ-008 In MEM_WAIT the block SHALL hold all enables 0 and dmem_req=1 while dmem_ack=0. In the cycle dmem_ack=1 it SHALL:
- drive all enables 1 and dmem_req=0;
- return to RUN on the next edge.
REQ-009 An ack arriving in the same cycle as the request in RUN SHALL cause no stall (zero-wait access).
REQ-010 A 4-bit wait counter SHALL increment in each MEM_WAIT cycle with ack=0. On reaching 15 it SHALL:
- set dmem_timeout (sticky until reset);
- force a return to RUN with mem_wr_bubble=1 and all enables 1.
REQ-011 dmem_req SHALL equal mem_access in RUN and LU_STALL, and SHALL be 1 in MEM_WAIT.
REQ-012 forwardA SHALL be combinational and SHALL select as follows (forwardB is identical using id_Rt):
- 10 if mem_RegWr=1, mem_Rw!=0 and mem_Rw==id_Rs;
- else 01 if wr_RegWr=1, wr_Rw!=0 and wr_Rw==id_Rs;
- else 00.
REQ-013 stall_cnt SHALL increment by 1 in every cycle where pc_en=0, and SHALL saturate at 16'hFFFF.
REQ-014 Outputs other than forwardA, forwardB and dmem_req SHALL be decoded from the registered state and the current inputs only. There SHALL be no combinational path from dmem_ack to forwardA or forwardB.

Reset
REQ-015 When Rst_n=0 at a rising edge, the block SHALL set state=RUN, wait counter=0, stall_cnt=0 and dmem_timeout=0. Reset SHALL take priority over all other events, including mid-MEM_WAIT.
REQ-016 While Rst_n=0, the block SHALL drive all enables 1, all flush and bubble signals 0, and dmem_req=0.

Verification
REQ-017 Load r5 in EX with id_Rs=5 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; then LU_STALL with forwardA=10 (load in MEM); stall_cnt=1.
REQ-018 ex_branch_taken=1 simultaneous with a load-use hazard -> if_id_flush=1 and id_ex_flush=1 for one cycle, pc_en=1, no LU_STALL entered.
REQ-019 mem_access=1 with dmem_ack rising after 3 cycles -> all enables 0 for 3 cycles, dmem_req=1 throughout, return to RUN, stall_cnt=3.
REQ-020 mem_access=1 with dmem_ack held 0 -> dmem_timeout=1 after 15 wait cycles, mem_wr_bubble=1 for one cycle, FSM back in RUN.
REQ-021 mem_Rw=wr_Rw=7 with both RegWr=1 and id_Rs=7 -> forwardA=10; with mem_Rw=0 -> forwardA=01; with all Rw=0 -> forwardA=00.
REQ-022 Rst_n=0 asserted in the second cycle of MEM_WAIT -> next edge state=RUN, stall_cnt=0, dmem_timeout=0, dmem_req=0.
